cr_kme_drbg_seed_mgr: RTL and testbench

// Parametrised DRBG seed-slot manager for the KME KDF path. Holds NUM_SEEDS seed

---
 rtl/cr_kme_drbg_seed_mgr.sv | 117 +++++++++++
 tb/tb_cr_kme_drbg_seed_mgr.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cr_kme_drbg_seed_mgr.sv
// rtl/cr_kme_drbg_seed_mgr.sv - DRBG seed-slot manager: per-slot valid, use counting, auto-expiry, req/ack serving
module cr_kme_drbg_seed_mgr #(
    parameter int          NUM_SEEDS = 2,
    parameter int          KEY_W     = 256,
    parameter int          VAL_W     = 128,
    parameter int          RI_W      = 48,
    parameter logic [10:0] CTRL_ADDR = 11'h308,
    parameter logic [10:0] STAT_ADDR = 11'h30C,
    parameter int          SEL_W     = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_stb,
    input  logic [31:0]                wr_data,
    input  logic [10:0]                reg_addr,
    input  logic [NUM_SEEDS*KEY_W-1:0] seed_key_in,
    input  logic [NUM_SEEDS*VAL_W-1:0] seed_val_in,
    input  logic [NUM_SEEDS*RI_W-1:0]  seed_ri_in,
    input  logic [NUM_SEEDS-1:0]       seed_invalidate,
    input  logic                       gen_req,
    input  logic [SEL_W-1:0]           gen_sel,
    output logic                       gen_ack,
    output logic                       gen_err,
    output logic [KEY_W-1:0]           gen_key,
    output logic [VAL_W-1:0]           gen_val,
    output logic [NUM_SEEDS-1:0]       seed_valid,
    output logic [NUM_SEEDS-1:0]       expired_status,
    output logic                       set_drbg_expired_int
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t                 state, state_nxt;
    logic                   accept;
    logic                   ctrl_wr, stat_wr;
    logic [NUM_SEEDS-1:0]   good, expire, fall;
    logic [RI_W-1:0]        cnt     [NUM_SEEDS];
    logic [RI_W:0]          cnt_inc [NUM_SEEDS];
    logic [RI_W-1:0]        ri_i;
    logic [KEY_W-1:0]       key_mux;
    logic [VAL_W-1:0]       val_mux;
    logic                   unused_wr;

    assign unused_wr = ^wr_data;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // RESP always returns to IDLE, so requests are taken at most every other cycle
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (gen_req) begin
                accept    = 1'b1;
                state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ctrl_wr = wr_stb && (reg_addr == CTRL_ADDR);
        stat_wr = wr_stb && (reg_addr == STAT_ADDR);
        key_mux = '0;
        val_mux = '0;
        ri_i    = '0;
        for (int i = 0; i < NUM_SEEDS; i++) begin
            // Out-of-range selects match no slot and therefore produce an error
            good[i]    = accept && (gen_sel == SEL_W'(i)) && seed_valid[i] && !seed_invalidate[i];
            ri_i       = seed_ri_in[i*RI_W +: RI_W];
            cnt_inc[i] = {1'b0, cnt[i]} + {{RI_W{1'b0}}, 1'b1};
            expire[i]  = good[i] && (ri_i != '0) && (cnt_inc[i] == {1'b0, ri_i});
            fall[i]    = seed_valid[i] && (seed_invalidate[i] || expire[i]);
            key_mux    = key_mux | (good[i] ? seed_key_in[i*KEY_W +: KEY_W] : '0);
            val_mux    = val_mux | (good[i] ? seed_val_in[i*VAL_W +: VAL_W] : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seed_valid           <= '0;
            expired_status       <= '0;
            set_drbg_expired_int <= 1'b0;
            for (int i = 0; i < NUM_SEEDS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SEEDS; i++) begin
                if (seed_invalidate[i] || expire[i]) seed_valid[i] <= 1'b0;
                else if (ctrl_wr)                    seed_valid[i] <= wr_data[i];

                if (ctrl_wr && wr_data[i])  cnt[i] <= '0;
                else if (good[i])           cnt[i] <= cnt_inc[i][RI_W] ? cnt[i] : cnt_inc[i][RI_W-1:0];
            end
            // A new expiry in the same cycle as a W1C keeps the flag set
            expired_status       <= (expired_status & ~(stat_wr ? wr_data[NUM_SEEDS-1:0] : '0)) | fall;
            set_drbg_expired_int <= |fall;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gen_ack <= 1'b0;
            gen_err <= 1'b0;
            gen_key <= '0;
            gen_val <= '0;
        end else begin
            gen_ack <= accept;
            gen_err <= accept && !(|good);
            gen_key <= key_mux;
            gen_val <= val_mux;
        end
    end

endmodule

// File: tb/tb_cr_kme_drbg_seed_mgr.sv
// tb/tb_cr_kme_drbg_seed_mgr.sv - directed self-checking bench for cr_kme_drbg_seed_mgr
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end end

module tb_cr_kme_drbg_seed_mgr;

    localparam logic [255:0] K0 = {8{32'h0123_4567}};
    localparam logic [255:0] K1 = {8{32'h89AB_CDEF}};
    localparam logic [127:0] V0 = {4{32'h1111_2222}};
    localparam logic [127:0] V1 = {4{32'h3333_4444}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_stb;
    logic [31:0]  wr_data;
    logic [10:0]  reg_addr;
    logic [511:0] seed_key_in;
    logic [255:0] seed_val_in;
    logic [95:0]  seed_ri_in;
    logic [1:0]   seed_invalidate;
    logic         gen_req;
    logic [2:0]   gen_sel;
    logic         gen_ack;
    logic         gen_err;
    logic [255:0] gen_key;
    logic [127:0] gen_val;
    logic [1:0]   seed_valid;
    logic [1:0]   expired_status;
    logic         set_drbg_expired_int;

    int checks = 0;
    int errors = 0;
    int bad    = 0;

    always #5 clk = ~clk;

    cr_kme_drbg_seed_mgr dut (
        .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .wr_data(wr_data), .reg_addr(reg_addr),
        .seed_key_in(seed_key_in), .seed_val_in(seed_val_in), .seed_ri_in(seed_ri_in),
        .seed_invalidate(seed_invalidate), .gen_req(gen_req), .gen_sel(gen_sel),
        .gen_ack(gen_ack), .gen_err(gen_err), .gen_key(gen_key), .gen_val(gen_val),
        .seed_valid(seed_valid), .expired_status(expired_status),
        .set_drbg_expired_int(set_drbg_expired_int)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [10:0] a, input logic [31:0] d);
        wr_stb = 1'b1; reg_addr = a; wr_data = d;
        tick();
        wr_stb = 1'b0;
    endtask

    // Leaves the bench in the RESP cycle, where ack/err/key/val are visible
    task automatic gen(input logic [2:0] sel);
        gen_req = 1'b1; gen_sel = sel;
        tick();
        gen_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_stb = 1'b0; wr_data = '0; reg_addr = '0;
        seed_key_in = {K1, K0}; seed_val_in = {V1, V0};
        seed_ri_in = {48'd0, 48'd3};
        seed_invalidate = '0; gen_req = 1'b0; gen_sel = '0;
        tick(); tick();
        `CHK("rst_valid", seed_valid, 2'b00)
        `CHK("rst_status", expired_status, 2'b00)
        `CHK("rst_ack", gen_ack, 1'b0)
        `CHK("rst_int", set_drbg_expired_int, 1'b0)
        `CHK("rst_key", gen_key, 256'd0)
        rst_n = 1'b1;

        reg_wr(11'h308, 32'h3);
        `CHK("ctrl_valid", seed_valid, 2'b11)

        gen(3'd1);
        `CHK("g1_ack", gen_ack, 1'b1)
        `CHK("g1_err", gen_err, 1'b0)
        `CHK("g1_key", gen_key, K1)
        `CHK("g1_val", gen_val, V1)
        tick();
        `CHK("g1_ack_drop", gen_ack, 1'b0)

        gen(3'd0); `CHK("ri_g1_err", gen_err, 1'b0) tick();
        gen(3'd0); `CHK("ri_g2_err", gen_err, 1'b0) `CHK("ri_g2_int", set_drbg_expired_int, 1'b0) tick();
        gen(3'd0);
        `CHK("ri_g3_ack", gen_ack, 1'b1)
        `CHK("ri_g3_err", gen_err, 1'b0)
        `CHK("ri_g3_key", gen_key, K0)
        `CHK("ri_g3_valid", seed_valid, 2'b10)
        `CHK("ri_g3_int", set_drbg_expired_int, 1'b1)
        `CHK("ri_g3_status", expired_status, 2'b01)
        tick();
        `CHK("ri_int_once", set_drbg_expired_int, 1'b0)
        gen(3'd0);
        `CHK("ri_g4_err", gen_err, 1'b1)
        `CHK("ri_g4_key", gen_key, 256'd0)
        tick();

        seed_invalidate = 2'b10;
        gen(3'd1);
        seed_invalidate = 2'b00;
        `CHK("inv_ack", gen_ack, 1'b1)
        `CHK("inv_err", gen_err, 1'b1)
        `CHK("inv_valid", seed_valid, 2'b00)
        `CHK("inv_int", set_drbg_expired_int, 1'b1)
        `CHK("inv_status", expired_status, 2'b11)
        tick();
        seed_invalidate = 2'b10;
        tick();
        seed_invalidate = 2'b00;
        `CHK("inv_again_int", set_drbg_expired_int, 1'b0)
        `CHK("inv_again_status", expired_status, 2'b11)

        reg_wr(11'h30C, 32'h3);
        `CHK("w1c_all", expired_status, 2'b00)
        reg_wr(11'h308, 32'h3);
        `CHK("sw_set_no_int", set_drbg_expired_int, 1'b0)
        seed_invalidate = 2'b11;
        tick();
        seed_invalidate = 2'b00;
        `CHK("both_int", set_drbg_expired_int, 1'b1)
        `CHK("both_status", expired_status, 2'b11)
        `CHK("both_valid", seed_valid, 2'b00)
        tick();
        `CHK("both_int_once", set_drbg_expired_int, 1'b0)
        reg_wr(11'h30C, 32'h1);
        `CHK("w1c_bit0", expired_status, 2'b10)

        gen(3'd5);
        `CHK("sel5_ack", gen_ack, 1'b1)
        `CHK("sel5_err", gen_err, 1'b1)
        tick();

        wr_stb = 1'b1; reg_addr = 11'h308; wr_data = 32'h1;
        gen(3'd0);
        wr_stb = 1'b0;
        `CHK("wr_accept_err", gen_err, 1'b1)
        `CHK("wr_accept_valid", seed_valid, 2'b01)
        tick();

        seed_ri_in = {48'd0, 48'd0};
        for (int n = 0; n < 1000; n++) begin
            gen(3'd0);
            if (gen_err !== 1'b0 || gen_ack !== 1'b1 || set_drbg_expired_int !== 1'b0) bad++;
            tick();
        end
        `CHK("ri0_bad_acks", bad, 0)
        `CHK("ri0_valid", seed_valid, 2'b01)

        gen(3'd0);
        `CHK("pre_rst_ack", gen_ack, 1'b1)
        rst_n = 1'b0;
        tick();
        `CHK("mid_rst_ack", gen_ack, 1'b0)
        `CHK("mid_rst_key", gen_key, 256'd0)
        `CHK("mid_rst_val", gen_val, 128'd0)
        `CHK("mid_rst_valid", seed_valid, 2'b00)
        `CHK("mid_rst_status", expired_status, 2'b00)
        rst_n = 1'b1;
        gen(3'd0);
        `CHK("post_rst_ack", gen_ack, 1'b1)
        `CHK("post_rst_err", gen_err, 1'b1)
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
